mul_seq: RTL and testbench

Sequential multiply-accumulate unit computing P = Q*B + R over LEN-bit unsigned operands, one partial product per cycle. It is the inverse companion of the sequential divider: feeding it the divider's quotient, divisor and remainder reconstructs the dividend. It uses the same START/DONE handshake, so one bench harness drives both blocks. It sits beside the divider in the arithmetic cluster and is used for divide-result checking and scaled-address computation.

---
 rtl/mul_seq.sv | 122 ++++++++++++
 tb/tb_mul_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential multiply-accumulate P = Q*B + R, one shift-add step per cycle, START/DONE handshake.
// Optional macro MUL_SEQ_RADIX4_EN: two multiplier bits per step using a precomputed 3Q.
`timescale 1ns/1ps
module mul_seq #(
    parameter int LEN = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [LEN-1:0]    Q,
    input  logic [LEN-1:0]    B,
    input  logic [LEN-1:0]    R,
    output logic              DONE,
    output logic [2*LEN-1:0]  P
);

`ifdef MUL_SEQ_RADIX4_EN
    localparam int STEPS = LEN / 2;
    localparam int SH    = 2;

    if (LEN % 2 != 0) begin : g_len_odd
        $error("mul_seq: LEN must be even when MUL_SEQ_RADIX4_EN is defined");
    end
`else
    localparam int STEPS = LEN;
    localparam int SH    = 1;
`endif

    localparam int AW = 2 * LEN + 1;
    localparam int CW = $clog2(STEPS + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic             last_step;
    logic [AW-1:0]    acc;
    logic [2*LEN-1:0] mc;
    logic [LEN-1:0]   mpl;
    logic [2*LEN-1:0] pp;

    // The product can never reach the carry bit; saturate defensively rather than wrap.
    function automatic logic [2*LEN-1:0] sat_result(input logic [AW-1:0] a);
        return a[AW-1] ? '1 : a[2*LEN-1:0];
    endfunction

    assign last_step = (cnt == CW'(STEPS - 1));

`ifdef MUL_SEQ_RADIX4_EN
    logic [2*LEN-1:0] mc3;

    always_ff @(posedge CLK) begin
        if (START)
            mc3 <= (2*LEN)'(Q) + ((2*LEN)'(Q) << 1);
        else if (state == RUN)
            mc3 <= mc3 << 2;
    end

    always_comb begin
        pp = '0;
        case (mpl[1:0])
            2'd0:    pp = '0;
            2'd1:    pp = mc;
            2'd2:    pp = {mc[2*LEN-2:0], 1'b0};
            default: pp = mc3;
        endcase
    end
`else
    always_comb begin
        pp = mpl[0] ? mc : '0;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (START)
            state_next = RUN;
        else if (state == RUN && last_step)
            state_next = HOLD;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt <= '0;
        else if (START)
            cnt <= '0;
        else if (state == RUN)
            cnt <= cnt + 1'b1;
    end

    // R enters the accumulator at load, so each step only adds the shifted partial product.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            acc <= '0;
        else if (START)
            acc <= AW'(R);
        else if (state == RUN)
            acc <= acc + AW'(pp);
    end

    always_ff @(posedge CLK) begin
        if (START) begin
            mc  <= (2*LEN)'(Q);
            mpl <= B;
        end else if (state == RUN) begin
            mc  <= mc << SH;
            mpl <= mpl >> SH;
        end
    end

    assign DONE = (state == HOLD);
    assign P    = sat_result(acc);

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: randomized and directed operations against an arithmetic model.
`timescale 1ns/1ps
module tb_mul_seq;

    localparam int LEN = 16;
`ifdef MUL_SEQ_RADIX4_EN
    localparam int LAT = LEN / 2;
`else
    localparam int LAT = LEN;
`endif

    logic              CLK;
    logic              RST_N;
    logic              START;
    logic [LEN-1:0]    Q;
    logic [LEN-1:0]    B;
    logic [LEN-1:0]    R;
    logic              DONE;
    logic [2*LEN-1:0]  P;

    int errors = 0;
    int checks = 0;

    mul_seq #(.LEN(LEN)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .Q     (Q),
        .B     (B),
        .R     (R),
        .DONE  (DONE),
        .P     (P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [2*LEN-1:0] model(input logic [LEN-1:0] q, input logic [LEN-1:0] b,
                                               input logic [LEN-1:0] r);
        longint unsigned v;
        v = longint'(q) * longint'(b) + longint'(r);
        return v[2*LEN-1:0];
    endfunction

    // Called at a negedge; START is sampled on the following posedge (edge 0).
    task automatic do_start(input logic [LEN-1:0] q, input logic [LEN-1:0] b, input logic [LEN-1:0] r);
        START = 1'b1;
        Q = q;
        B = b;
        R = r;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        Q = 'x;
        B = 'x;
        R = 'x;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge CLK);
            @(negedge CLK);
            cyc++;
        end while (DONE !== 1'b1 && cyc < 40);
    endtask

    task automatic test_reset;
        int bad;
        RST_N = 1'b0;
        START = 1'b0;
        Q = 'x;
        B = 'x;
        R = 'x;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0 || P !== '0) begin
            errors++;
            $display("FAIL reset_asserted: DONE=%b P=%h expected DONE=0 P=0", DONE, P);
        end
        RST_N = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE !== 1'b0 || P !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d bad cycles, last DONE=%b P=%h expected DONE=0 P=0", bad, DONE, P);
        end
    endtask

    task automatic test_basic;
        int cyc;
        int bad;
        logic [2*LEN-1:0] exp;
        exp = 32'h0062572E;
        do_start(16'h1234, 16'h0567, 16'h0042);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges expected %0d", cyc, LAT);
        end
        checks++;
        if (P !== exp) begin
            errors++;
            $display("FAIL basic_result: P=%h expected %h", P, exp);
        end
        bad = 0;
        repeat (10) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE !== 1'b1 || P !== exp) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL basic_hold: %0d bad cycles, DONE=%b P=%h expected DONE=1 P=%h", bad, DONE, P, exp);
        end
    endtask

    task automatic test_extremes;
        int cyc;
        do_start(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || P !== 32'hFFFF0000) begin
            errors++;
            $display("FAIL extreme_max: edges=%0d P=%h expected edges=%0d P=ffff0000", cyc, P, LAT);
        end
        do_start(16'h5A5A, 16'h0000, 16'h00AB);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || P !== 32'h000000AB) begin
            errors++;
            $display("FAIL extreme_b_zero: edges=%0d P=%h expected edges=%0d P=000000ab", cyc, P, LAT);
        end
    endtask

    task automatic test_random;
        int cyc;
        logic [LEN-1:0] q, b, r;
        logic [2*LEN-1:0] exp;
        for (int n = 0; n < 30; n++) begin
            q = LEN'($urandom);
            b = LEN'($urandom);
            r = LEN'($urandom);
            exp = model(q, b, r);
            do_start(q, b, r);
            wait_done(cyc);
            checks++;
            if (cyc !== LAT || P !== exp) begin
                errors++;
                $display("FAIL random[%0d]: q=%h b=%h r=%h edges=%0d P=%h expected edges=%0d P=%h",
                         n, q, b, r, cyc, P, LAT, exp);
            end
        end
    endtask

    task automatic test_abort;
        int cyc;
        int early;
        do_start(16'h1234, 16'h0567, 16'h0000);
        early = 0;
        repeat (4) begin
            @(posedge CLK);
            @(negedge CLK);
            if (DONE !== 1'b0) early++;
        end
        do_start(16'h0003, 16'h0005, 16'h0001);
        if (DONE !== 1'b0) early++;
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL abort_no_stale_done: DONE seen high %0d times expected 0", early);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || P !== 32'h00000010) begin
            errors++;
            $display("FAIL abort_result: edges=%0d P=%h expected edges=%0d P=00000010", cyc, P, LAT);
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        do_start(16'hABCD, 16'hFFFF, 16'h1111);
        repeat (6) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (DONE !== 1'b0 || P !== '0) begin
            errors++;
            $display("FAIL reset_mid_run_async: DONE=%b P=%h expected DONE=0 P=0", DONE, P);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        do_start(16'h0BEE, 16'h00F1, 16'h0077);
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || P !== model(16'h0BEE, 16'h00F1, 16'h0077)) begin
            errors++;
            $display("FAIL reset_mid_run_restart: edges=%0d P=%h expected edges=%0d P=%h",
                     cyc, P, LAT, model(16'h0BEE, 16'h00F1, 16'h0077));
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        do_start(16'h00FF, 16'h0101, 16'h0003);
        wait_done(cyc);
        do_start(16'h7777, 16'h0002, 16'h0009);
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_drop: DONE=%b expected 0 after restart", DONE);
        end
        wait_done(cyc);
        checks++;
        if (cyc !== LAT || P !== 32'h0000EEF7) begin
            errors++;
            $display("FAIL back_to_back_result: edges=%0d P=%h expected edges=%0d P=0000eef7", cyc, P, LAT);
        end
    endtask

    task automatic test_inverse;
        int cyc;
        int bad;
        logic [LEN-1:0] a, b, q, r;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            a = LEN'(i * 193);
            b = LEN'(i * 1543);
            if (b == 0) begin
                q = 16'hFFFF;
                r = a;
            end else begin
                q = a / b;
                r = a % b;
            end
            do_start(q, b, r);
            wait_done(cyc);
            if (cyc !== LAT || P !== model(q, b, r)) bad++;
            if (b != 0 && P !== {16'h0000, a}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL inverse_sweep: %0d bad results out of 100 operations expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_random();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        test_inverse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
